// File: rtl/reset_route_pkg.sv
// rtl/reset_route_pkg.sv - shared types and constants for the reset-route enable sequencer
//
// Contents:
//   route_seq_state_t    sequencer FSM states
//   DEFAULT_*            default parameter values of reset_route_sequencer
//   RESET_*_CYCLES       default timing of the reset_route_reset endpoints
//   MIN_TIMEOUT_CYCLES   smallest handshake deadline a default endpoint can meet
//   idx_width()          route index width, never below 1
//   count_width()        width of a counter that must hold 0..limit

package reset_route_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UP_WAIT = 3'd1,
        ST_UP_GAP  = 3'd2,
        ST_ON      = 3'd3,
        ST_DN_WAIT = 3'd4,
        ST_DN_GAP  = 3'd5,
        ST_FAULT   = 3'd6
    } route_seq_state_t;

    localparam int DEFAULT_NUM_ROUTES     = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int DEFAULT_GAP_CYCLES     = 2;

    // Endpoint side: synchronizer depth plus its internal release gap.
    localparam int RESET_SYNC_CYCLES  = 2;
    localparam int RESET_GAP_CYCLES   = 4;
    // Endpoint latency plus input/output register stages on both sides.
    localparam int MIN_TIMEOUT_CYCLES = RESET_SYNC_CYCLES + RESET_GAP_CYCLES + 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int count_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/reset_route_sequencer_if.sv
// rtl/reset_route_sequencer_if.sv - sequencer handshake bundle toward controller and routes
//
// Signals:
//   start_req         controller level request (1 = all routes enabled)
//   start_ack         all routes enabled and sequencer in ON
//   route_enable_req  per-route enable request
//   route_enable_ack  per-route 4-phase acknowledge
//   busy              sequencing in progress
//   error             sticky fault flag
//   error_route       index of the faulting route
// Modports:
//   master  sequencer side
//   slave   controller/endpoint side

interface reset_route_sequencer_if
    import reset_route_pkg::*;
#(
    parameter int NUM_ROUTES = DEFAULT_NUM_ROUTES
) ();

    localparam int IDX_W = idx_width(NUM_ROUTES);

    logic                  start_req;
    logic                  start_ack;
    logic [NUM_ROUTES-1:0] route_enable_req;
    logic [NUM_ROUTES-1:0] route_enable_ack;
    logic                  busy;
    logic                  error;
    logic [IDX_W-1:0]      error_route;

    modport master (
        input  start_req,
        input  route_enable_ack,
        output start_ack,
        output route_enable_req,
        output busy,
        output error,
        output error_route
    );

    modport slave (
        output start_req,
        output route_enable_ack,
        input  start_ack,
        input  route_enable_req,
        input  busy,
        input  error,
        input  error_route
    );

endinterface

// File: rtl/reset_route_seq_timer.sv
// rtl/reset_route_seq_timer.sv - loadable saturating up-counter with a fixed compare point
//
// Ports:
//   clock, async_reset  clock and asynchronous active-high reset
//   clear               zero the count (highest priority)
//   enable              count this cycle
//   load, load_value    preload the count
//   hit                 high during the enabled cycle that is the LIMIT-th since clear,
//                       so the consumer acts on the edge where the count reaches LIMIT

module reset_route_seq_timer
    import reset_route_pkg::*;
#(
    parameter int LIMIT = 4,
    parameter int WIDTH = count_width(LIMIT)
) (
    input  logic             clock,
    input  logic             async_reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             hit
);

    localparam logic [WIDTH-1:0] SAT    = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] HIT_AT = (LIMIT > 0) ? WIDTH'(LIMIT - 1) : '0;

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != SAT)) begin
            count <= count + WIDTH'(1);
        end
    end

    // A zero limit means "expire on the first enabled cycle".
    assign hit = enable && ((LIMIT == 0) || (count == HIT_AT));

endmodule

// File: rtl/reset_route_sequencer.sv
// rtl/reset_route_sequencer.sv - ordered enable/disable sequencer for reset routes
//
// Ports:
//   clock        single clock
//   async_reset  asynchronous active-high reset; drops every request at once
//   bus          reset_route_sequencer_if.master (start_req/start_ack, per-route
//                req/ack, busy, error, error_route)
// Routes come up in ascending order and go down in descending order, one 4-phase
// handshake at a time, with GAP_CYCLES idle between routes and a TIMEOUT_CYCLES
// deadline on every handshake.

module reset_route_sequencer
    import reset_route_pkg::*;
#(
    parameter int NUM_ROUTES     = DEFAULT_NUM_ROUTES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES
) (
    input  logic                       clock,
    input  logic                       async_reset,
    reset_route_sequencer_if.master    bus
);

    localparam int                    IDX_W    = idx_width(NUM_ROUTES);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_ROUTES - 1);
    localparam logic [NUM_ROUTES-1:0] ALL_ON   = '1;

    route_seq_state_t      state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_ROUTES-1:0] req_q, req_d;
    logic                  error_q, error_d;
    logic [IDX_W-1:0]      error_route_q, error_route_d;
    logic                  start_ack_q;
    logic                  busy_q;

    // Inputs are registered once so that no output depends combinationally
    // on a pin; this is the "sampled at edge k" point of the handshake.
    logic                  start_q;
    logic [NUM_ROUTES-1:0] ack_q;

    logic                  tmo_clear, tmo_enable, tmo_hit;
    logic                  gap_clear, gap_enable, gap_hit;
    logic                  fault_go;
    logic [IDX_W-1:0]      fault_route;
    logic [IDX_W-1:0]      low_idx;
    logic [IDX_W-1:0]      idx_up, idx_dn;

    assign idx_up = idx_q + IDX_W'(1);
    assign idx_dn = idx_q - IDX_W'(1);

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            start_q <= 1'b0;
            ack_q   <= '0;
        end else begin
            start_q <= bus.start_req;
            ack_q   <= bus.route_enable_ack;
        end
    end

    // Lowest route whose ack has dropped while everything should be on.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_ROUTES - 1; i >= 0; i--) begin
            if (!ack_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign tmo_enable = (state_q == ST_UP_WAIT) || (state_q == ST_DN_WAIT);
    assign gap_enable = (state_q == ST_UP_GAP) || (state_q == ST_DN_GAP);

    reset_route_seq_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clock       (clock),
        .async_reset (async_reset),
        .clear       (tmo_clear),
        .enable      (tmo_enable),
        .load        (1'b0),
        .load_value  ('0),
        .hit         (tmo_hit)
    );

    reset_route_seq_timer #(.LIMIT(GAP_CYCLES)) u_gap (
        .clock       (clock),
        .async_reset (async_reset),
        .clear       (gap_clear),
        .enable      (gap_enable),
        .load        (1'b0),
        .load_value  ('0),
        .hit         (gap_hit)
    );

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // tmo_clear accompanies every req edge; gap_clear accompanies gap entry.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        req_d         = req_q;
        error_d       = error_q;
        error_route_d = error_route_q;
        tmo_clear     = 1'b0;
        gap_clear     = 1'b0;
        fault_go      = 1'b0;
        fault_route   = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    idx_d     = '0;
                    req_d[0]  = 1'b1;
                    tmo_clear = 1'b1;
                    state_d   = ST_UP_WAIT;
                end
            end

            ST_UP_WAIT: begin
                // Abort beats a simultaneous ack, so a drop on the last ack
                // never passes through ON with start_ack set.
                if (!start_q) begin
                    req_d[idx_q] = 1'b0;
                    tmo_clear    = 1'b1;
                    state_d      = ST_DN_WAIT;
                end else if (ack_q[idx_q]) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_ON;
                    end else if (GAP_CYCLES == 0) begin
                        idx_d         = idx_up;
                        req_d[idx_up] = 1'b1;
                        tmo_clear     = 1'b1;
                    end else begin
                        gap_clear = 1'b1;
                        state_d   = ST_UP_GAP;
                    end
                end else if (tmo_hit) begin
                    fault_go = 1'b1;
                end
            end

            ST_UP_GAP: begin
                if (!start_q) begin
                    req_d[idx_q] = 1'b0;
                    tmo_clear    = 1'b1;
                    state_d      = ST_DN_WAIT;
                end else if (gap_hit) begin
                    idx_d         = idx_up;
                    req_d[idx_up] = 1'b1;
                    tmo_clear     = 1'b1;
                    state_d       = ST_UP_WAIT;
                end
            end

            ST_ON: begin
                if (!start_q) begin
                    idx_d           = LAST_IDX;
                    req_d[LAST_IDX] = 1'b0;
                    tmo_clear       = 1'b1;
                    state_d         = ST_DN_WAIT;
                end else if (ack_q != ALL_ON) begin
                    fault_go    = 1'b1;
                    fault_route = low_idx;
                end
            end

            ST_DN_WAIT: begin
                if (!ack_q[idx_q]) begin
                    if (idx_q == '0) begin
                        state_d = ST_IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        idx_d         = idx_dn;
                        req_d[idx_dn] = 1'b0;
                        tmo_clear     = 1'b1;
                    end else begin
                        gap_clear = 1'b1;
                        state_d   = ST_DN_GAP;
                    end
                end else if (tmo_hit) begin
                    fault_go = 1'b1;
                end
            end

            ST_DN_GAP: begin
                if (gap_hit) begin
                    idx_d         = idx_dn;
                    req_d[idx_dn] = 1'b0;
                    tmo_clear     = 1'b1;
                    state_d       = ST_DN_WAIT;
                end
            end

            ST_FAULT: begin
                if (!start_q && (ack_q == '0)) begin
                    error_d       = 1'b0;
                    error_route_d = '0;
                    state_d       = ST_IDLE;
                end
            end

            default: begin
                req_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (fault_go) begin
            req_d         = '0;
            error_d       = 1'b1;
            error_route_d = fault_route;
            state_d       = ST_FAULT;
        end
    end

    // Status outputs are decoded from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            idx_q         <= '0;
            req_q         <= '0;
            error_q       <= 1'b0;
            error_route_q <= '0;
            start_ack_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            req_q         <= req_d;
            error_q       <= error_d;
            error_route_q <= error_route_d;
            start_ack_q   <= (state_d == ST_ON);
            busy_q        <= !((state_d == ST_IDLE) || (state_d == ST_ON) ||
                               (state_d == ST_FAULT));
        end
    end

    assign bus.route_enable_req = req_q;
    assign bus.start_ack        = start_ack_q;
    assign bus.busy             = busy_q;
    assign bus.error            = error_q;
    assign bus.error_route      = error_route_q;

endmodule

// File: tb/tb_reset_route_sequencer.sv
// tb/tb_reset_route_sequencer.sv - directed bench for reset_route_sequencer with endpoint models

module tb_reset_route_sequencer;

    logic       clock = 1'b0;
    logic       async_reset;
    logic       start_req;
    logic [3:0] tie_low;
    logic [3:0] force_low;
    logic [3:0] ep_d1;
    logic [3:0] ep_d2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int         req_rise [4];
    int         req_fall [4];
    int         sa_rise;
    int         sa_fall;
    int         err_rise;
    logic [3:0] req_at_err;
    logic [3:0] req_prev = '0;
    logic       sa_prev = 1'b0;
    logic       err_prev = 1'b0;
    int         phase = 0;
    int         seen_phase = -1;

    int t0;
    int t1;

    reset_route_sequencer_if #(.NUM_ROUTES(4)) bus ();

    reset_route_sequencer #(
        .NUM_ROUTES     (4),
        .TIMEOUT_CYCLES (64),
        .GAP_CYCLES     (2)
    ) dut (
        .clock       (clock),
        .async_reset (async_reset),
        .bus         (bus.master)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Endpoint model: ack follows req two cycles later, resets with the block.
    always @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            ep_d1 <= '0;
            ep_d2 <= '0;
        end else begin
            ep_d1 <= bus.route_enable_req;
            ep_d2 <= ep_d1;
        end
    end

    assign bus.start_req        = start_req;
    assign bus.route_enable_ack = ep_d2 & ~tie_low & ~force_low;

    // Edge recorder; marks are cleared whenever the stimulus bumps phase.
    always @(negedge clock) begin
        if (seen_phase != phase) begin
            seen_phase = phase;
            for (int i = 0; i < 4; i++) begin
                req_rise[i] = -1;
                req_fall[i] = -1;
            end
            sa_rise    = -1;
            sa_fall    = -1;
            err_rise   = -1;
            req_at_err = 4'hx;
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.route_enable_req[i] && !req_prev[i]) req_rise[i] = cyc;
            if (!bus.route_enable_req[i] && req_prev[i]) req_fall[i] = cyc;
        end
        if (bus.start_ack && !sa_prev) sa_rise = cyc;
        if (!bus.start_ack && sa_prev) sa_fall = cyc;
        if (bus.error && !err_prev) begin
            err_rise   = cyc;
            req_at_err = bus.route_enable_req;
        end
        req_prev = bus.route_enable_req;
        sa_prev  = bus.start_ack;
        err_prev = bus.error;
    end

    task automatic check_eq(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        async_reset = 1'b1;
        start_req   = 1'b0;
        tie_low     = '0;
        force_low   = '0;
        wait_cycles(3);
        check_eq("rst_req",         bus.route_enable_req, 0);
        check_eq("rst_start_ack",   bus.start_ack, 0);
        check_eq("rst_busy",        bus.busy, 0);
        check_eq("rst_error",       bus.error, 0);
        check_eq("rst_error_route", bus.error_route, 0);
        async_reset = 1'b0;
        wait_cycles(3);

        // Power-up: req[i] at t0+2+6i, start_ack at t0+24.
        @(negedge clock);
        phase++;
        t0 = cyc;
        start_req = 1'b1;
        wait_cycles(5);
        check_eq("up_busy", bus.busy, 1);
        wait_cycles(35);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("up_req%0d_rise", i), req_rise[i], t0 + 2 + 6 * i);
        check_eq("up_start_ack_rise", sa_rise, t0 + 24);
        check_eq("up_start_ack", bus.start_ack, 1);
        check_eq("up_busy_on", bus.busy, 0);
        check_eq("up_error", bus.error, 0);

        // Shutdown: req[3] at t1+2, then every 6 cycles downward.
        phase++;
        t1 = cyc;
        start_req = 1'b0;
        wait_cycles(40);
        check_eq("dn_start_ack_fall", sa_fall, t1 + 2);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("dn_req%0d_fall", i), req_fall[i], t1 + 2 + 6 * (3 - i));
        check_eq("dn_busy", bus.busy, 0);
        check_eq("dn_req", bus.route_enable_req, 0);

        // Route 2 never acks: fault 64 cycles after req[2] rises (t0+14).
        tie_low = 4'b0100;
        phase++;
        t0 = cyc;
        start_req = 1'b1;
        wait_cycles(100);
        check_eq("tmo_req2_rise", req_rise[2], t0 + 14);
        check_eq("tmo_err_rise", err_rise, t0 + 78);
        check_eq("tmo_req_at_err", req_at_err, 0);
        check_eq("tmo_error", bus.error, 1);
        check_eq("tmo_error_route", bus.error_route, 2);
        check_eq("tmo_busy", bus.busy, 0);
        start_req = 1'b0;
        wait_cycles(10);
        check_eq("tmo_clr_error", bus.error, 0);
        check_eq("tmo_clr_route", bus.error_route, 0);
        check_eq("tmo_clr_busy", bus.busy, 0);
        tie_low = '0;
        wait_cycles(5);

        // Abort while waiting on route 1.
        phase++;
        t0 = cyc;
        start_req = 1'b1;
        wait_cycles(8);
        check_eq("abort_req_pre", bus.route_enable_req, 4'b0011);
        start_req = 1'b0;
        wait_cycles(30);
        check_eq("abort_req1_fall", req_fall[1], t0 + 10);
        check_eq("abort_order", int'(req_fall[0] > req_fall[1]), 1);
        check_eq("abort_no_start_ack", sa_rise, -1);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_req", bus.route_enable_req, 0);
        check_eq("abort_error", bus.error, 0);

        // One-cycle ack[1] dropout while ON.
        @(negedge clock);
        start_req = 1'b1;
        wait_cycles(40);
        check_eq("on_start_ack", bus.start_ack, 1);
        phase++;
        t1 = cyc;
        force_low = 4'b0010;
        @(negedge clock);
        force_low = '0;
        wait_cycles(5);
        check_eq("on_err_rise", err_rise, t1 + 2);
        check_eq("on_error_route", bus.error_route, 1);
        check_eq("on_start_ack_fall", sa_fall, t1 + 2);
        check_eq("on_req_at_err", req_at_err, 0);
        start_req = 1'b0;
        wait_cycles(10);
        check_eq("on_clr_error", bus.error, 0);

        // Asynchronous reset with route 2 pending.
        @(negedge clock);
        phase++;
        t0 = cyc;
        start_req = 1'b1;
        wait_cycles(15);
        check_eq("ar_req_pre", bus.route_enable_req, 4'b0111);
        #1 async_reset = 1'b1;
        #1;
        check_eq("ar_req",       bus.route_enable_req, 0);
        check_eq("ar_busy",      bus.busy, 0);
        check_eq("ar_start_ack", bus.start_ack, 0);
        check_eq("ar_error",     bus.error, 0);
        @(negedge clock);
        async_reset = 1'b0;
        phase++;
        t1 = cyc;
        wait_cycles(4);
        check_eq("ar_restart_req0", req_rise[0], t1 + 2);
        check_eq("ar_restart_req1", req_rise[1], -1);
        check_eq("ar_restart_req",  bus.route_enable_req, 4'b0001);
        start_req = 1'b0;
        wait_cycles(20);
        check_eq("end_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
